ft2232h_usbif_p: RTL

//  Parametrised FT2232H async-FIFO bridge. Adds programmable RD#/WR# strobe timing, internal RX/TX FIFOs

---
 rtl/ft2232h_usbif_p.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ft2232h_usbif_p.sv
// ft2232h_usbif_p: FT2232H async-FIFO bridge with programmable strobe timing and internal RX/TX FIFOs.
// Build option: define USBIF_SYNC2_EN to pass RXF#/TXE# through two-flop synchronisers.
module ft2232h_usbif_p_fifo #(
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == DEPTH);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr_q] <= din_i;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

module ft2232h_usbif_p #(
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 1,
    parameter int BACKOFF  = 1,
    parameter int AW       = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [7:0]    USB_DIN,
    output logic [7:0]    USB_DOUT,
    output logic          USB_DEN,
    output logic          USB_RDn,
    output logic          USB_WRn,
    input  logic          USB_RXFn,
    input  logic          USB_TXEn,
    input  logic [7:0]    TX_DATA,
    input  logic          TX_VALID,
    output logic          TX_READY,
    output logic [7:0]    RX_DATA,
    output logic          RX_VALID,
    input  logic          RX_READY,
    output logic [AW:0]   RX_LEVEL,
    output logic [AW:0]   TX_LEVEL
);
    localparam int CW = 8;
    localparam logic [CW-1:0] ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SU, S_WR_PL, S_BACKOFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdn_q, rdn_d, wrn_q, wrn_d, den_q, den_d;
    logic [7:0]    dout_q, dout_d;
    logic          last_wr_q, last_wr_d;
    logic          rxf_q, txe_q;
    logic          rx_push, tx_pop, rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic          rd_req, wr_req;

`ifdef USBIF_SYNC2_EN
    logic rxf_m_q, txe_m_q;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rxf_m_q <= 1'b0;
            txe_m_q <= 1'b0;
            rxf_q   <= 1'b0;
            txe_q   <= 1'b0;
        end else begin
            rxf_m_q <= ~USB_RXFn;
            txe_m_q <= ~USB_TXEn;
            rxf_q   <= rxf_m_q;
            txe_q   <= txe_m_q;
        end
    end
`else
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rxf_q <= 1'b0;
            txe_q <= 1'b0;
        end else begin
            rxf_q <= ~USB_RXFn;
            txe_q <= ~USB_TXEn;
        end
    end
`endif

    // Space is checked only at read start; one read in flight means the push never overflows.
    assign rd_req = rxf_q & ~rx_full;
    assign wr_req = txe_q & ~tx_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdn_d     = rdn_q;
        wrn_d     = wrn_q;
        den_d     = den_q;
        dout_d    = dout_q;
        last_wr_d = last_wr_q;
        rx_push   = 1'b0;
        tx_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // With both requests pending, alternate away from the previous operation.
                if (rd_req && (!wr_req || last_wr_q)) begin
                    rdn_d   = 1'b0;
                    cnt_d   = CW'(RD_WAIT);
                    state_d = S_RD;
                end else if (wr_req) begin
                    tx_pop  = 1'b1;
                    dout_d  = tx_head;
                    den_d   = 1'b1;
                    cnt_d   = CW'(WR_SETUP);
                    state_d = S_WR_SU;
                end
            end
            S_RD: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    rx_push   = 1'b1;
                    rdn_d     = 1'b1;
                    last_wr_d = 1'b0;
                    cnt_d     = CW'(BACKOFF);
                    state_d   = S_BACKOFF;
                end
            end
            S_WR_SU: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    wrn_d   = 1'b0;
                    cnt_d   = CW'(WR_PULSE);
                    state_d = S_WR_PL;
                end
            end
            S_WR_PL: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    wrn_d     = 1'b1;
                    den_d     = 1'b0;
                    last_wr_d = 1'b1;
                    cnt_d     = CW'(BACKOFF);
                    state_d   = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            den_q     <= 1'b0;
            dout_q    <= '0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
            den_q     <= den_d;
            dout_q    <= dout_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign USB_RDn  = rdn_q;
    assign USB_WRn  = wrn_q;
    assign USB_DEN  = den_q;
    assign USB_DOUT = dout_q;
    assign RX_VALID = ~rx_empty;
    assign TX_READY = ~tx_full;

    ft2232h_usbif_p_fifo #(.AW(AW)) u_rx_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .push_i  (rx_push),
        .din_i   (USB_DIN),
        .pop_i   (RX_READY),
        .dout_o  (RX_DATA),
        .level_o (RX_LEVEL),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    ft2232h_usbif_p_fifo #(.AW(AW)) u_tx_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .push_i  (TX_VALID),
        .din_i   (TX_DATA),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .level_o (TX_LEVEL),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );
endmodule
